add_reducer_scheduler: RTL and testbench

Sequences a multi-beat vector reduction through the pipelined 8-input Add_Reducer datapath. It accepts a job of N beats, each carrying ADDENDS words. It streams the beats into the reducer, tracks in-flight beats with a tag pipeline matched to the reducer latency, and accumulates the per-beat reductions into a single result. The block sits between a requester (e.g. a thread's I/O port) and one external Add_Reducer instance.

---
 rtl/add_reducer_scheduler.sv | 110 +++++++++++
 tb/tb_add_reducer_scheduler.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/add_reducer_scheduler.sv
// Job sequencer for a pipelined 8-input add reducer: streams beats out, tags them
// through a latency-matched shift register, and accumulates the tagged reductions.
module add_reducer_scheduler #(
  parameter int WORD_WIDTH      = 36,
  parameter int ADDENDS         = 8,
  parameter int REDUCER_LATENCY = 3,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [COUNT_WIDTH-1:0]        beat_count,
  output logic                          busy,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDENDS*WORD_WIDTH-1:0] in_addends,
  output logic [ADDENDS*WORD_WIDTH-1:0] red_addends,
  input  logic [WORD_WIDTH-1:0]         red_reduction,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [WORD_WIDTH-1:0]         result
);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic [WORD_WIDTH-1:0]      acc_q, acc_d;
  logic [WORD_WIDTH-1:0]      result_q, result_d;
  logic [REDUCER_LATENCY-1:0] tag_q, tag_d;
  logic [REDUCER_LATENCY-1:0] tag_rest;
  logic                       tag_in, tag_out, last_tag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    tag_in      = 1'b0;
    in_ready    = 1'b0;
    red_addends = '0;

    tag_out  = tag_q[REDUCER_LATENCY-1];
    tag_rest = tag_q;
    tag_rest[REDUCER_LATENCY-1] = 1'b0;
    last_tag = tag_out && (tag_rest == '0);

    // Untagged reducer output is ignored; tags die on reset, discarding in-flight beats.
    if (tag_out) acc_d = acc_q + red_reduction;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          if (beat_count != '0) begin
            cnt_d   = beat_count;
            state_d = FEED;
          end else begin
            result_d = '0;
            state_d  = DONE;
          end
        end
      end
      FEED: begin
        in_ready = 1'b1;
        if (in_valid) begin
          red_addends = in_addends;
          tag_in      = 1'b1;
          cnt_d       = cnt_q - 1'b1;
          if (cnt_q == COUNT_WIDTH'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_tag) begin
          result_d = acc_d;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shift then insert keeps this valid for a single-stage pipe as well.
    tag_d    = tag_q << 1;
    tag_d[0] = tag_in;
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == DONE);
  assign result       = result_q;

endmodule

// File: tb/tb_add_reducer_scheduler.sv
// Directed and randomized jobs against an external latency-3 reducer model;
// expected sums are computed from the beat words with plain modular arithmetic.
module tb_add_reducer_scheduler;

  localparam int W  = 36;
  localparam int A  = 8;
  localparam int L  = 3;
  localparam int CW = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [CW-1:0]     beat_count;
  logic              busy;
  logic              in_valid;
  logic              in_ready;
  logic [A*W-1:0]    in_addends;
  logic [A*W-1:0]    red_addends;
  logic [W-1:0]      red_reduction;
  logic              result_valid;
  logic              result_ready;
  logic [W-1:0]      result;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  logic [A*W-1:0] beats[$];
  logic [W-1:0]   pipe[L];

  add_reducer_scheduler #(
    .WORD_WIDTH(W), .ADDENDS(A), .REDUCER_LATENCY(L), .COUNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .beat_count(beat_count),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_addends(in_addends),
    .red_addends(red_addends), .red_reduction(red_reduction),
    .result_valid(result_valid), .result_ready(result_ready), .result(result)
  );

  always #5 clock = ~clock;

  function automatic logic [W-1:0] word_sum(input logic [A*W-1:0] b);
    logic [W-1:0] s = '0;
    for (int i = 0; i < A; i++) s = s + b[i*W +: W];
    return s;
  endfunction

  // External reducer: not reset, so aborted beats stay in flight.
  always @(posedge clock) begin
    pipe[0] <= word_sum(red_addends);
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign red_reduction = pipe[L-1];

  task automatic chk(input string tag, input logic [A*W-1:0] obs, input logic [A*W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [A*W-1:0] fill(input logic [W-1:0] v);
    logic [A*W-1:0] b;
    for (int i = 0; i < A; i++) b[i*W +: W] = v;
    return b;
  endfunction

  function automatic logic [A*W-1:0] ramp(input int base);
    logic [A*W-1:0] b;
    for (int i = 0; i < A; i++) b[i*W +: W] = W'(i + base);
    return b;
  endfunction

  function automatic logic [A*W-1:0] rnd_beat();
    logic [A*W-1:0] b;
    for (int i = 0; i < A; i++) b[i*W +: W] = {$urandom, $urandom} & {W{1'b1}};
    return b;
  endfunction

  // Runs the job held in beats[]; called at posedge+1 with the DUT idle.
  task automatic run_job(input int gap, input int hold);
    int n;
    int lat;
    logic [W-1:0] exp_sum;
    n = beats.size();
    exp_sum = '0;
    foreach (beats[i]) exp_sum = exp_sum + word_sum(beats[i]);

    start = 1'b1;
    beat_count = CW'(n);
    @(posedge clock); #1;
    start = 1'b0;
    chk("busy_after_start", A*W'(busy), A*W'(1));

    if (n == 0) begin
      chk("zero_job_valid", A*W'(result_valid), A*W'(1));
      chk("zero_job_ready", A*W'(in_ready), A*W'(0));
    end else begin
      for (int b = 0; b < n; b++) begin
        for (int g = 0; b > 0 && g < gap; g++) begin
          in_valid = 1'b0;
          in_addends = rnd_beat();
          #1;
          chk("bubble_ready", A*W'(in_ready), A*W'(1));
          chk("bubble_red_zero", red_addends, '0);
          @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_addends = beats[b];
        #1;
        chk("accept_ready", A*W'(in_ready), A*W'(1));
        chk("pass_through", red_addends, beats[b]);
        @(posedge clock); #1;
      end
      in_valid = 1'b0;
      in_addends = fill(W'(5));
      #1;
      chk("drain_ready_low", A*W'(in_ready), A*W'(0));
      chk("drain_red_zero", red_addends, '0);
      lat = 0;
      while (!result_valid && lat < 20) begin
        @(posedge clock); #1;
        lat++;
      end
      chk("result_latency", A*W'(lat), A*W'(L));
    end

    chk("result_value", A*W'(result), A*W'(exp_sum));
    for (int k = 0; k < hold; k++) begin
      start = k[0];
      beat_count = CW'(3);
      @(posedge clock); #1;
      chk("hold_valid", A*W'(result_valid), A*W'(1));
      chk("hold_result", A*W'(result), A*W'(exp_sum));
      chk("hold_ready_low", A*W'(in_ready), A*W'(0));
    end
    start = 1'b0;
    result_ready = 1'b1;
    @(posedge clock); #1;
    result_ready = 1'b0;
    chk("idle_busy", A*W'(busy), A*W'(0));
    chk("idle_valid", A*W'(result_valid), A*W'(0));
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    beat_count = '0;
    in_valid = 1'b0;
    in_addends = '0;
    result_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
    end
    chk("reset_busy", A*W'(busy), A*W'(0));
    chk("reset_ready", A*W'(in_ready), A*W'(0));
    chk("reset_valid", A*W'(result_valid), A*W'(0));
    chk("reset_result", A*W'(result), A*W'(0));
    reset = 1'b0;
    @(posedge clock); #1;

    beats = {fill(W'(1))};
    run_job(0, 0);
    chk("single_is_8", A*W'(result), A*W'(8));

    beats = {ramp(0), ramp(1), fill(W'(1))};
    run_job(0, 0);

    beats = {fill(W'(1)), fill(W'(1)), fill(W'(1)), fill(W'(1))};
    run_job(2, 0);

    beats.delete();
    run_job(0, 0);

    beats = {fill(W'(36'h8_0000_0000))};
    run_job(0, 0);

    beats = {ramp(3), ramp(7)};
    run_job(1, 5);

    // Abort a 4-beat job after two accepted beats.
    start = 1'b1;
    beat_count = CW'(4);
    @(posedge clock); #1;
    start = 1'b0;
    in_valid = 1'b1;
    in_addends = ramp(100);
    @(posedge clock); #1;
    in_addends = ramp(200);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", A*W'(busy), A*W'(0));
    chk("abort_ready", A*W'(in_ready), A*W'(0));
    chk("abort_red_zero", red_addends, '0);
    chk("abort_valid", A*W'(result_valid), A*W'(0));
    chk("abort_result", A*W'(result), A*W'(0));
    in_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    beats = {fill(W'(1))};
    run_job(0, 0);
    chk("post_abort_is_8", A*W'(result), A*W'(8));

    for (int j = 0; j < 12; j++) begin
      int n;
      n = int'($urandom_range(1, 6));
      beats.delete();
      for (int b = 0; b < n; b++) beats.push_back(rnd_beat());
      run_job(int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
